exe_stage: RTL

Execute stage of the ARM pipeline. It consumes the ID/EX register outputs and the operand produced by the `Val2_Generator`, and it performs the ALU operation and the branch-target addition. It owns the NZCV status register and drives the EX/MEM pipeline register that feeds the memory stage.

---
 rtl/arm_defs.sv | 27 ++
 rtl/alu.sv | 77 +++++++
 rtl/exe_stage.sv | 113 +++++++++++
 3 files changed

// File: rtl/arm_defs.sv
// Shared definitions for the ARM pipeline.
// Holds the execute-stage command encodings, which the decoder also uses,
// the NZCV bit positions inside the status nibble, and the datapath width.
package arm_defs;

  localparam int DATA_W = 32;

  // ALU command encodings carried on exe_cmd
  typedef enum logic [3:0] {
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } exe_cmd_t;

  // Bit positions of the flags inside the 4-bit status {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu.sv
// Combinational ALU of the execute stage.
// Ports:
//   a, b   : operands (a = Rn value, b = shifter operand)
//   cmd    : exe_cmd encoding from arm_defs
//   c_in   : current C flag, consumed by ADC/SBC and passed through by logical ops
//   v_in   : current V flag, passed through by logical ops
//   res    : 32-bit result
//   nzcv   : flags the instruction would produce if it sets status
module alu
  import arm_defs::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        cmd,
  input  logic              c_in,
  input  logic              v_in,
  output logic [DATA_W-1:0] res,
  output logic [3:0]        nzcv
);

  // Two's-complement overflow: operands of like sign give a result of the other sign
  function automatic logic add_ovf(input logic signed [DATA_W-1:0] x,
                                   input logic signed [DATA_W-1:0] y,
                                   input logic signed [DATA_W-1:0] r);
    return ((x < 0) == (y < 0)) && ((r < 0) != (x < 0));
  endfunction

  // Subtraction overflows when operand signs differ and the result sign leaves x's
  function automatic logic sub_ovf(input logic signed [DATA_W-1:0] x,
                                   input logic signed [DATA_W-1:0] y,
                                   input logic signed [DATA_W-1:0] r);
    return ((x < 0) != (y < 0)) && ((r < 0) != (x < 0));
  endfunction

  logic [DATA_W:0] wide;
  logic            c_out;
  logic            v_out;

  always_comb begin
    wide  = '0;
    res   = '0;
    c_out = c_in;
    v_out = v_in;
    case (cmd)
      CMD_MOV: res = b;
      CMD_MVN: res = ~b;
      CMD_ADD, CMD_ADC: begin
        wide  = {1'b0, a} + {1'b0, b}
              + {{DATA_W{1'b0}}, (cmd == CMD_ADC) & c_in};
        res   = wide[DATA_W-1:0];
        c_out = wide[DATA_W];
        v_out = add_ovf(a, b, wide[DATA_W-1:0]);
      end
      CMD_SUB, CMD_SBC: begin
        // Bit 32 of the 33-bit difference is the borrow; ARM's C is its inverse
        wide  = {1'b0, a} - {1'b0, b}
              - {{DATA_W{1'b0}}, (cmd == CMD_SBC) & ~c_in};
        res   = wide[DATA_W-1:0];
        c_out = ~wide[DATA_W];
        v_out = sub_ovf(a, b, wide[DATA_W-1:0]);
      end
      CMD_AND: res = a & b;
      CMD_ORR: res = a | b;
      CMD_EOR: res = a ^ b;
      default: res = '0;
    endcase
  end

  always_comb begin
    nzcv         = '0;
    nzcv[FLAG_N] = res[DATA_W-1];
    nzcv[FLAG_Z] = (res == '0);
    nzcv[FLAG_C] = c_out;
    nzcv[FLAG_V] = v_out;
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage of the ARM pipeline.
// Runs the ALU on the ID/EX operands, owns the NZCV status register, computes
// the branch target, and loads the EX/MEM pipeline register.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   freeze                   : stall; EX/MEM and status hold
//   valid_in                 : ID/EX slot carries a real instruction
//   exe_cmd, wb_en, mem_r_en, mem_w_en, s_bit, branch : ID/EX control
//   pc, val_rn, val_rm, val_2, signed_imm_24, dest     : ID/EX data
//   status                   : registered {N,Z,C,V}
//   branch_taken/address     : combinational branch resolution
//   ex_*                     : EX/MEM register outputs
module exe_stage
  import arm_defs::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              valid_in,
  input  logic [3:0]        exe_cmd,
  input  logic              wb_en,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic              s_bit,
  input  logic              branch,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] val_rn,
  input  logic [DATA_W-1:0] val_rm,
  input  logic [DATA_W-1:0] val_2,
  input  logic [23:0]       signed_imm_24,
  input  logic [3:0]        dest,
  output logic [3:0]        status,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_address,
  output logic              ex_valid,
  output logic              ex_wb_en,
  output logic              ex_mem_r_en,
  output logic              ex_mem_w_en,
  output logic [DATA_W-1:0] ex_alu_res,
  output logic [DATA_W-1:0] ex_val_rm,
  output logic [3:0]        ex_dest
);

  logic [DATA_W-1:0]        alu_res_p0;
  logic [3:0]               nzcv_p0;
  logic signed [DATA_W-1:0] br_off_p0;

  logic [3:0]        status_p1;
  logic              vld_p1;
  logic              wb_en_p1;
  logic              mem_r_en_p1;
  logic              mem_w_en_p1;
  logic [DATA_W-1:0] alu_res_p1;
  logic [DATA_W-1:0] val_rm_p1;
  logic [3:0]        dest_p1;

  // Stage p0: ALU and branch adder, fed straight from ID/EX
  alu u_alu (
    .a    (val_rn),
    .b    (val_2),
    .cmd  (exe_cmd),
    .c_in (status_p1[FLAG_C]),
    .v_in (status_p1[FLAG_V]),
    .res  (alu_res_p0),
    .nzcv (nzcv_p0)
  );

  // Word offset, sign-extended and scaled by 4
  assign br_off_p0      = {{6{signed_imm_24[23]}}, signed_imm_24, 2'b00};
  assign branch_address = pc + DATA_W'(br_off_p0);
  assign branch_taken   = valid_in & branch;

  // Stage p1: status register and EX/MEM register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_p1 <= '0;
    end else if (valid_in && s_bit && !freeze) begin
      status_p1 <= nzcv_p0;
    end
  end

  // Control bits are qualified by valid so a bubble can never write back or
  // access memory; data fields are captured as-is.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1      <= 1'b0;
      wb_en_p1    <= 1'b0;
      mem_r_en_p1 <= 1'b0;
      mem_w_en_p1 <= 1'b0;
      alu_res_p1  <= '0;
      val_rm_p1   <= '0;
      dest_p1     <= '0;
    end else if (!freeze) begin
      vld_p1      <= valid_in;
      wb_en_p1    <= wb_en    & valid_in;
      mem_r_en_p1 <= mem_r_en & valid_in;
      mem_w_en_p1 <= mem_w_en & valid_in;
      alu_res_p1  <= alu_res_p0;
      val_rm_p1   <= val_rm;
      dest_p1     <= dest;
    end
  end

  assign status      = status_p1;
  assign ex_valid    = vld_p1;
  assign ex_wb_en    = wb_en_p1;
  assign ex_mem_r_en = mem_r_en_p1;
  assign ex_mem_w_en = mem_w_en_p1;
  assign ex_alu_res  = alu_res_p1;
  assign ex_val_rm   = val_rm_p1;
  assign ex_dest     = dest_p1;

endmodule
